// File: rtl/ss_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver: dead-time blanking, BCD decode, PWM brightness,
// leading-zero blanking. Optional per-digit blink when SS_BLINK_EN is defined.
module ss_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 131072,
  parameter int BLANK_CYC = 64,
  parameter int PWM_W     = 8,
  parameter int BLINK_W   = 8,
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [4*DIGITS-1:0] Bcd,
  input  logic [DIGITS-1:0]   DpIn,
  input  logic [PWM_W-1:0]    Bright,
  input  logic                LzbEn,
`ifdef SS_BLINK_EN
  input  logic [DIGITS-1:0]   BlinkMask,
`endif
  output logic [DIGITS-1:0]   SegmentDrivers,
  output logic [7:0]          SevenSegment,
  output logic [IDX_W-1:0]    DigitIdx
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK, ON} state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              slot_last;
  logic              idx_last;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [3:0]        lat_nib;
  logic              lat_dp;
  logic              lat_lzb;
  logic              lat_blk;
  logic [3:0]        cur_nib;
  logic              upper_zero;
  logic              lzb_now;
  logic              blink_bit;
  logic              blink_off;
  logic              lit;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign slot_nxt  = slot_last ? '0 : slot_cnt + 1'b1;
  assign idx_last  = (DigitIdx == IDX_W'(DIGITS - 1));
  assign cur_nib   = Bcd[4*int'(DigitIdx) +: 4];

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(DigitIdx) && Bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    lzb_now = LzbEn && (DigitIdx != '0) && upper_zero;
  end

`ifdef SS_BLINK_EN
  logic [BLINK_W:0] frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) frame_cnt <= '0;
    else if (slot_last && idx_last) frame_cnt <= frame_cnt + 1'b1;
  end

  assign blink_bit = BlinkMask[DigitIdx];
  assign blink_off = frame_cnt[BLINK_W];
`else
  assign blink_bit = 1'b0;
  assign blink_off = 1'b0;
`endif

  assign lit = (pwm_cnt < Bright) && !lat_lzb && !(blink_off && lat_blk);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= BLANK;
      slot_cnt       <= '0;
      DigitIdx       <= '0;
      pwm_cnt        <= '0;
      lat_nib        <= '0;
      lat_dp         <= 1'b0;
      lat_lzb        <= 1'b0;
      lat_blk        <= 1'b0;
      SegmentDrivers <= '1;
      SevenSegment   <= 8'hFF;
    end else begin
      slot_cnt <= slot_nxt;
      pwm_cnt  <= pwm_cnt + 1'b1;
      state    <= (slot_nxt < SLOT_W'(BLANK_CYC)) ? BLANK : ON;
      if (slot_last) DigitIdx <= idx_last ? '0 : DigitIdx + 1'b1;

      // Slot start is always blanked, so the snapshot is in place before the digit lights.
      if (slot_cnt == '0) begin
        lat_nib <= cur_nib;
        lat_dp  <= DpIn[DigitIdx];
        lat_lzb <= lzb_now;
        lat_blk <= blink_bit;
      end

      if (state == ON) begin
        SegmentDrivers <= ~(DIGITS'(1) << DigitIdx);
        SevenSegment   <= lit ? ~{lat_dp, glyph(lat_nib)} : 8'hFF;
      end else begin
        SegmentDrivers <= '1;
        SevenSegment   <= 8'hFF;
      end
    end
  end

endmodule
